// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared opcodes and FSM encoding
// for the SPI serial-memory master.
package spi_mem_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_CMD  = 3'd1;
   localparam state_t ST_ADDR = 3'd2;
   localparam state_t ST_DATA = 3'd3;
   localparam state_t ST_GAP  = 3'd4;

endpackage

// File: rtl/spi_mem_master_sck_gen.sv
// spi_sck_gen: divides clk into a mode-0 SCK and
// gives one-cycle strobes on the clk edge where SCK rises/falls.
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;
   logic          tick;

   assign tick   = en_i && (cnt_q == CNT_MAX);
   assign rise_o = tick && !sck_q;
   assign fall_o = tick && sck_q;
   assign sck_o  = sck_q;

   // Half-period counter; SCK parks low whenever disabled.
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!en_i) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (tick) begin
         cnt_d = '0;
         sck_d = !sck_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 master for serial memories.
// Sends opcode, address, then a burst of read or write bytes.
module spi_mem_master
   import spi_mem_pkg::*;
#(
   parameter int ADDR_BYTES = 1,
   parameter int CLK_DIV    = 2,
   parameter int LEN_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [8*ADDR_BYTES-1:0] req_addr,
   input  logic [LEN_W-1:0]        req_len,
   input  logic [7:0]              wr_data,
   output logic                    wr_ready,
   output logic [7:0]              rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    spi_cs_n,
   output logic                    spi_sck,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int BW = (LEN_W > 2) ? LEN_W : 2;
   localparam int GW = $clog2(2 * CLK_DIV);
   localparam logic [GW-1:0] GAP_MAX   = GW'(2 * CLK_DIV - 1);
   localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);

   state_t           state_q, state_d;
   logic             write_q, write_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [BW-1:0]    byte_q, byte_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             done_q, done_d;
   logic             cs_n_q, cs_n_d;
   logic             ready_q, ready_d;
   logic [GW-1:0]    gap_q, gap_d;

   logic       sck_en, rise, fall;
   logic       byte_end, addr_last, data_last;
   logic [7:0] next_data;

   assign sck_en = (state_q == ST_CMD) ||
                   (state_q == ST_ADDR) ||
                   (state_q == ST_DATA);

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck (
      .clk    (clk),
      .rst    (rst),
      .en_i   (sck_en),
      .sck_o  (spi_sck),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign byte_end  = fall && (bit_q == 3'd7);
   assign addr_last = (byte_q == ADDR_LAST);
   assign data_last = (byte_q == BW'(len_q));
   assign next_data = write_q ? wr_data : 8'h00;

   // Ask for a write byte on the fall that will shift its MSB out.
   assign wr_ready = write_q && byte_end &&
                     (((state_q == ST_ADDR) && addr_last) ||
                      ((state_q == ST_DATA) && !data_last));

   assign req_ready = ready_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_mosi  = tx_q[7];

   // Transaction sequencer: shift on falls, sample on rises.
   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      addr_d     = addr_q;
      len_d      = len_q;
      byte_d     = byte_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      cs_n_d     = cs_n_q;
      gap_d      = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && ready_q) begin
               state_d = ST_CMD;
               write_d = req_write;
               addr_d  = req_addr;
               len_d   = req_len;
               byte_d  = '0;
               bit_d   = 3'd0;
               tx_d    = req_write ? CMD_WRITE : CMD_READ;
               cs_n_d  = 1'b0;
            end
         end
         ST_CMD, ST_ADDR, ST_DATA: begin
            if (rise) begin
               rx_d = {rx_q[6:0], spi_miso};
               if ((state_q == ST_DATA) && !write_q &&
                   (bit_q == 3'd7)) begin
                  rd_data_d  = {rx_q[6:0], spi_miso};
                  rd_valid_d = 1'b1;
               end
            end
            if (fall) begin
               bit_d = bit_q + 3'd1;
               tx_d  = {tx_q[6:0], 1'b0};
               if (bit_q == 3'd7) begin
                  if (state_q == ST_CMD) begin
                     state_d = ST_ADDR;
                     byte_d  = '0;
                     tx_d    = addr_q[AW-1 -: 8];
                     addr_d  = addr_q << 8;
                  end else if (state_q == ST_ADDR) begin
                     if (addr_last) begin
                        state_d = ST_DATA;
                        byte_d  = '0;
                        tx_d    = next_data;
                     end else begin
                        byte_d = byte_q + 1'b1;
                        tx_d   = addr_q[AW-1 -: 8];
                        addr_d = addr_q << 8;
                     end
                  end else if (data_last) begin
                     state_d = ST_GAP;
                     gap_d   = '0;
                     cs_n_d  = 1'b1;
                     done_d  = 1'b1;
                     tx_d    = 8'h00;
                  end else begin
                     byte_d = byte_q + 1'b1;
                     tx_d   = next_data;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_MAX) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // State registers; reset drops CS and aborts any transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         write_q    <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         byte_q     <= '0;
         bit_q      <= 3'd0;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         ready_q    <= 1'b0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         byte_q     <= byte_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         cs_n_q     <= cs_n_d;
         ready_q    <= ready_d;
         gap_q      <= gap_d;
      end
   end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: directed bench with a behavioural
// SPI memory slave and a second narrow-divider instance.
module tb_spi_mem_master;

   localparam time CLK_P = 10;

   logic clk = 1'b0;
   always #(CLK_P / 2) clk = ~clk;

   logic rst;

   logic       req_valid, req_ready, req_write;
   logic [7:0] req_addr;
   logic [3:0] req_len;
   logic [7:0] wr_data, rd_data;
   logic       wr_ready, rd_valid, busy, done;
   logic       cs_n, sck, mosi, miso;

   spi_mem_master #(
      .ADDR_BYTES (1),
      .CLK_DIV    (2),
      .LEN_W      (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .done      (done),
      .spi_cs_n  (cs_n),
      .spi_sck   (sck),
      .spi_mosi  (mosi),
      .spi_miso  (miso)
   );

   logic        req_valid2, req_ready2, req_write2;
   logic [15:0] req_addr2;
   logic [3:0]  req_len2;
   logic [7:0]  wr_data2, rd_data2;
   logic        wr_ready2, rd_valid2, busy2, done2;
   logic        cs_n2, sck2, mosi2, miso2;

   assign miso2 = 1'b1;

   spi_mem_master #(
      .ADDR_BYTES (2),
      .CLK_DIV    (1),
      .LEN_W      (4)
   ) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid2),
      .req_ready (req_ready2),
      .req_write (req_write2),
      .req_addr  (req_addr2),
      .req_len   (req_len2),
      .wr_data   (wr_data2),
      .wr_ready  (wr_ready2),
      .rd_data   (rd_data2),
      .rd_valid  (rd_valid2),
      .busy      (busy2),
      .done      (done2),
      .spi_cs_n  (cs_n2),
      .spi_sck   (sck2),
      .spi_mosi  (mosi2),
      .spi_miso  (miso2)
   );

   int nvec = 0;
   int nerr = 0;

   logic [7:0] dat  [0:15];
   logic [7:0] wbuf [0:63];
   logic [5:0] widx = 6'd0;
   logic       adv  = 1'b0;
   assign wr_data = wbuf[widx];

   // Behavioural mode-0 memory slave (1 address byte).
   logic [7:0] mem  [0:255];
   logic [7:0] mlog [0:63];
   int         bitcnt   = 0;
   int         mcnt     = 0;
   int         rise_cnt = 0;
   logic [7:0] sr = 8'h00, scmd = 8'h00, ptr = 8'h00, txb = 8'h00;

   always @(posedge sck or negedge sck or posedge cs_n) begin
      if (cs_n === 1'b1) begin
         bitcnt = 0;
         miso   = 1'b0;
      end else if (sck === 1'b1) begin
         sr = {sr[6:0], mosi};
         bitcnt++;
         rise_cnt++;
         if (bitcnt % 8 == 0) begin
            mlog[6'(mcnt)] = sr;
            mcnt++;
            if (bitcnt == 8) scmd = sr;
            else if (bitcnt == 16) ptr = sr;
            else if (scmd == 8'h02) begin
               mem[ptr] = sr;
               ptr      = ptr + 8'd1;
            end
         end
      end else begin
         if (bitcnt >= 16 && bitcnt % 8 == 0 && scmd == 8'h03) begin
            txb = mem[ptr];
            ptr = ptr + 8'd1;
         end else begin
            txb = {txb[6:0], 1'b0};
         end
         miso = txb[7];
      end
   end

   // Capture for the second instance: MOSI bits, rises, rise times.
   logic [63:0] sh2 = 64'd0;
   int          rise2 = 0;
   time         tprev2 = 0, tlast2 = 0;

   always @(posedge sck2) begin
      if (cs_n2 === 1'b0) begin
         sh2    = {sh2[62:0], mosi2};
         rise2++;
         tprev2 = tlast2;
         tlast2 = $time;
      end
   end

   // Pulse monitor sampled mid-cycle.
   logic [7:0] rd_log [0:63];
   int         rdv_cnt = 0, wrr_cnt = 0, done_cnt = 0, viol_cnt = 0;
   int         rdv2 = 0;
   logic [7:0] rd2_last = 8'h00;

   always @(negedge clk) begin
      if (adv) begin
         widx = widx + 6'd1;
         adv  = 1'b0;
      end
      if (wr_ready === 1'b1) begin
         wrr_cnt++;
         adv = 1'b1;
      end
      if (rd_valid === 1'b1) begin
         rd_log[6'(rdv_cnt)] = rd_data;
         rdv_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if ((req_ready === 1'b1 && busy === 1'b1) ||
          (done === 1'b1 && cs_n !== 1'b1)) viol_cnt++;
      if (rd_valid2 === 1'b1) begin
         rdv2++;
         rd2_last = rd_data2;
      end
   end

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         nvec++; nerr++;
         $display("FAIL %s ready-timeout: req_ready=%b want 1", tag, req_ready);
      end
   endtask

   task automatic run_txn(input logic w, input logic [7:0] a,
                          input logic [3:0] l, input string tag);
      int r0, m0, d0, w0, s0, n, k, g;
      logic [7:0] op;
      op = w ? 8'h02 : 8'h03;
      n  = int'(l) + 1;
      if (w) for (int i = 0; i < n; i++) wbuf[widx + 6'(i)] = dat[i];
      wait_ready(tag);
      r0 = rdv_cnt; m0 = mcnt; d0 = done_cnt; w0 = wrr_cnt; s0 = rise_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
      @(posedge clk); #1;
      req_valid = 1'b0;
      nvec++;
      if ({cs_n, mosi, busy, req_ready} !== {1'b0, op[7], 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL %s accept: cs/mosi/busy/rdy=%b want %b", tag,
                  {cs_n, mosi, busy, req_ready}, {1'b0, op[7], 1'b1, 1'b0});
      end
      k = 0;
      while (done !== 1'b1 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      nvec++;
      if (done !== 1'b1 || cs_n !== 1'b1) begin
         nerr++;
         $display("FAIL %s done: done=%b cs_n=%b want 1 1", tag, done, cs_n);
      end
      g = 0;
      while (req_ready !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      #1;
      nvec++;
      if (g != 4) begin
         nerr++;
         $display("FAIL %s gap: got %0d clks want 4", tag, g);
      end
      nvec++;
      if (rise_cnt - s0 != 8 * (2 + n)) begin
         nerr++;
         $display("FAIL %s rises: got %0d want %0d", tag, rise_cnt - s0, 8 * (2 + n));
      end
      nvec++;
      if (done_cnt - d0 != 1) begin
         nerr++;
         $display("FAIL %s done-count: got %0d want 1", tag, done_cnt - d0);
      end
      nvec++;
      if ({mlog[6'(m0)], mlog[6'(m0 + 1)]} !== {op, a}) begin
         nerr++;
         $display("FAIL %s mosi-hdr: got %h want %h", tag,
                  {mlog[6'(m0)], mlog[6'(m0 + 1)]}, {op, a});
      end
      nvec++;
      if (w ? (wrr_cnt - w0 != n || rdv_cnt != r0)
            : (rdv_cnt - r0 != n || wrr_cnt != w0)) begin
         nerr++;
         $display("FAIL %s pulses: wr_ready=%0d rd_valid=%0d want %0d/%0d", tag,
                  wrr_cnt - w0, rdv_cnt - r0, w ? n : 0, w ? 0 : n);
      end
      for (int i = 0; i < n; i++) begin
         nvec++;
         if (w) begin
            if (mlog[6'(m0 + 2 + i)] !== dat[i]) begin
               nerr++;
               $display("FAIL %s mosi-data[%0d]: got %h want %h", tag, i,
                        mlog[6'(m0 + 2 + i)], dat[i]);
            end
         end else begin
            if ({rd_log[6'(r0 + i)], mlog[6'(m0 + 2 + i)]} !== {dat[i], 8'h00}) begin
               nerr++;
               $display("FAIL %s rd[%0d]: rd_data=%h mosi=%h want %h 00", tag, i,
                        rd_log[6'(r0 + i)], mlog[6'(m0 + 2 + i)], dat[i]);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if ({cs_n, sck, mosi, req_ready, busy, done, rd_valid, wr_ready, rd_data}
          !== {1'b1, 7'b0, 8'h00}) begin
         nerr++;
         $display("FAIL reset-outputs: got %b want %b",
                  {cs_n, sck, mosi, req_ready, busy, done, rd_valid, wr_ready, rd_data},
                  {1'b1, 7'b0, 8'h00});
      end
      nvec++;
      if ({cs_n2, sck2, req_ready2, busy2} !== 4'b1000) begin
         nerr++;
         $display("FAIL reset-outputs2: got %b want 1000", {cs_n2, sck2, req_ready2, busy2});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if ({req_ready, req_ready2, busy} !== 3'b110) begin
         nerr++;
         $display("FAIL reset-release: ready/ready2/busy=%b want 110",
                  {req_ready, req_ready2, busy});
      end
   endtask

   task automatic test_read_single;
      dat[0] = 8'h10;
      run_txn(1'b0, 8'h00, 4'd0, "rd_single");
   endtask

   task automatic test_read_burst;
      dat[0] = 8'h55; dat[1] = 8'h29; dat[2] = 8'h77; dat[3] = 8'h77;
      run_txn(1'b0, 8'h0C, 4'd3, "rd_burst");
   endtask

   task automatic test_write_readback;
      dat[0] = 8'hA5; dat[1] = 8'h5A;
      run_txn(1'b1, 8'h20, 4'd1, "wr");
      run_txn(1'b0, 8'h20, 4'd1, "wr_readback");
   endtask

   task automatic test_max_len;
      for (int i = 0; i < 16; i++) dat[i] = 8'(i * 37 + 5);
      run_txn(1'b1, 8'h40, 4'hF, "wr_max");
      run_txn(1'b0, 8'h40, 4'hF, "rd_max");
   endtask

   task automatic test_reset_mid;
      int d0, r0;
      wait_ready("rst_mid");
      d0 = done_cnt; r0 = rdv_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; req_len = 4'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (40) @(negedge clk);
      nvec++;
      if ({busy, cs_n} !== 2'b10) begin
         nerr++;
         $display("FAIL rst_mid pre: busy/cs_n=%b want 10", {busy, cs_n});
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({cs_n, sck, mosi, busy, req_ready} !== 5'b10000) begin
         nerr++;
         $display("FAIL rst_mid abort: cs/sck/mosi/busy/rdy=%b want 10000",
                  {cs_n, sck, mosi, busy, req_ready});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1) begin
         nerr++;
         $display("FAIL rst_mid ready: got %b want 1", req_ready);
      end
      repeat (20) @(negedge clk);
      #1;
      nvec++;
      if (done_cnt != d0 || rdv_cnt != r0) begin
         nerr++;
         $display("FAIL rst_mid no-done: done=%0d rd_valid=%0d want 0 0",
                  done_cnt - d0, rdv_cnt - r0);
      end
      dat[0] = 8'h10;
      run_txn(1'b0, 8'h00, 4'd0, "rst_mid_after");
   endtask

   task automatic test_back_to_back;
      int d0, r0, v0, s0, acc, k;
      req_write = 1'b0; req_addr = 8'h00; req_len = 4'd0;
      wait_ready("b2b");
      d0 = done_cnt; r0 = rdv_cnt; v0 = viol_cnt; s0 = rise_cnt;
      acc = 0; k = 0;
      @(negedge clk);
      req_valid = 1'b1;
      while (acc < 2 && k < 2000) begin
         if (req_ready === 1'b1) begin
            acc++;
            if (acc == 2) begin
               @(posedge clk); #1;
               req_valid = 1'b0;
            end
         end
         if (acc < 2) @(negedge clk);
         k++;
      end
      req_valid = 1'b0;
      k = 0;
      while (done_cnt - d0 < 2 && k < 2000) begin
         @(negedge clk); #1;
         k++;
      end
      wait_ready("b2b_end");
      repeat (10) @(negedge clk);
      #1;
      nvec++;
      if (acc != 2 || done_cnt - d0 != 2) begin
         nerr++;
         $display("FAIL b2b count: accepts=%0d done=%0d want 2 2", acc, done_cnt - d0);
      end
      nvec++;
      if (rdv_cnt - r0 != 2 || rise_cnt - s0 != 48) begin
         nerr++;
         $display("FAIL b2b traffic: rd_valid=%0d rises=%0d want 2 48",
                  rdv_cnt - r0, rise_cnt - s0);
      end
      nvec++;
      if ({rd_log[6'(r0)], rd_log[6'(r0 + 1)]} !== 16'h1010) begin
         nerr++;
         $display("FAIL b2b data: got %h want 1010", {rd_log[6'(r0)], rd_log[6'(r0 + 1)]});
      end
      nvec++;
      if (viol_cnt != v0) begin
         nerr++;
         $display("FAIL b2b ready-while-busy: got %0d events want 0", viol_cnt - v0);
      end
   endtask

   task automatic test_div1;
      int s0, r0, k, g;
      k = 0;
      while (req_ready2 !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      s0 = rise2; r0 = rdv2;
      @(negedge clk);
      req_valid2 = 1'b1; req_addr2 = 16'h0001;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      nvec++;
      if ({cs_n2, mosi2, busy2} !== 3'b001) begin
         nerr++;
         $display("FAIL div1 accept: cs/mosi/busy=%b want 001", {cs_n2, mosi2, busy2});
      end
      k = 0;
      while (done2 !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      nvec++;
      if (done2 !== 1'b1 || cs_n2 !== 1'b1) begin
         nerr++;
         $display("FAIL div1 done: done=%b cs_n=%b want 1 1", done2, cs_n2);
      end
      g = 0;
      while (req_ready2 !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      #1;
      nvec++;
      if (g != 2) begin
         nerr++;
         $display("FAIL div1 gap: got %0d clks want 2", g);
      end
      nvec++;
      if (rise2 - s0 != 32) begin
         nerr++;
         $display("FAIL div1 rises: got %0d want 32", rise2 - s0);
      end
      nvec++;
      if (sh2[31:0] !== 32'h0300_0100) begin
         nerr++;
         $display("FAIL div1 mosi: got %h want 03000100", sh2[31:0]);
      end
      nvec++;
      if (tlast2 - tprev2 != 2 * CLK_P) begin
         nerr++;
         $display("FAIL div1 sck-period: got %0t want %0t", tlast2 - tprev2, 2 * CLK_P);
      end
      nvec++;
      if (rdv2 - r0 != 1 || rd2_last !== 8'hFF) begin
         nerr++;
         $display("FAIL div1 read: rd_valid=%0d data=%h want 1 ff", rdv2 - r0, rd2_last);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h10;
      mem[8'h0C] = 8'h55;
      mem[8'h0D] = 8'h29;
      mem[8'h0E] = 8'h77;
      mem[8'h0F] = 8'h77;
      for (int i = 0; i < 64; i++) wbuf[i] = 8'h00;
      req_valid  = 1'b0; req_write  = 1'b0; req_addr  = 8'h00; req_len  = 4'd0;
      req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = 16'h0; req_len2 = 4'd0;
      wr_data2   = 8'h00;
      test_reset;
      test_read_single;
      test_read_burst;
      test_write_readback;
      test_max_len;
      test_reset_mid;
      test_back_to_back;
      test_div1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
